dqs_read_gate: RTL and testbench
================================

DQS_READ_GATE -- requirements
Module: dqs_read_gate

Interface
REQ-001 Parameter LANES, default 2: number of DQS byte lanes, 1..8.
REQ-002 Parameter BURST_LEN, default 8: DDR beats per read; even, 2..16; lane valid window = BURST_LEN/2 SCLK cycles.
REQ-003 Parameter PRMB_CYC, default 1: minimum consecutive low DQSS samples forming a preamble, 1..3.
REQ-004 Parameter TIMEOUT, default 15: maximum cycles a lane waits for a preamble, 1..2^LATW-1.
REQ-005 Parameter LATW, default 4: width of each per-lane latency field.
REQ-006 SCLK  in  1  system clock; all logic rising-edge.
REQ-007 RSTN  in  1  asynchronous active-low reset.
REQ-008 READ  in  1  read-burst request, one-cycle pulse.
REQ-009 DQSS  in  LANES  per-lane DQS level, sampled in the SCLK domain.
REQ-010 DQSGATE  out  LANES  per-lane DQS gate enable.
REQ-011 PRMBDET  out  LANES  per-lane one-cycle preamble-detect pulse.
REQ-012 DATAVALID  out  LANES  per-lane read-data valid.
REQ-013 DATAVALID_ALL  out  1  AND of all DATAVALID bits.
REQ-014 TMOERR  out  LANES  per-lane sticky timeout flag.
REQ-015 OVERRUN  out  1  sticky flag: READ arrived while busy.
REQ-016 BUSY  out  1  OR over lanes of state != IDLE.
REQ-017 RDLAT  out  LANES*LATW  per-lane measured preamble latency; lane i occupies bits [i*LATW +: LATW].

Function
REQ-018 Each lane SHALL run an independent FSM with states IDLE, WAIT, BURST; all lanes start together.
REQ-019 READ=1 with BUSY=0 at edge t SHALL move every lane to WAIT at t+1, clear TMOERR, OVERRUN and the wait counters, and zero every lane's low-run counter.
REQ-020 READ=1 with BUSY=1 SHALL be ignored and set OVERRUN at the next edge.
REQ-021 In WAIT, the low-run counter SHALL increment (saturating at PRMB_CYC) on DQSS=0 and clear on DQSS=1 when the detect condition (REQ-022) fails.
REQ-022 In WAIT, DQSS=1 with low-run >= PRMB_CYC SHALL be a detect: PRMBDET=1 for that cycle only, RDLAT lane := wait count (cycles since WAIT entry, 0-based), and next state = BURST.
REQ-023 PRMBDET SHALL be combinational on the detect condition; all other outputs SHALL be registered.
REQ-024 In BURST, DATAVALID SHALL be 1 for exactly BURST_LEN/2 consecutive cycles, starting the cycle after detect; the lane then returns to IDLE.
REQ-025 The wait counter reaching TIMEOUT without a detect SHALL return the lane to IDLE and set its TMOERR; RDLAT keeps its previous value.
REQ-026 If a detect and the timeout occur in the same cycle, the detect SHALL win.
REQ-027 DQSGATE SHALL be 1 in WAIT and BURST, and 0 in IDLE.
REQ-028 RDLAT SHALL saturate at 2^LATW-1.
REQ-029 A lane finishing early SHALL stay IDLE until every lane is IDLE and a new READ is accepted.

Reset
REQ-030 RSTN=0 SHALL asynchronously force all FSMs to IDLE and all counters to 0, and set DQSGATE, DATAVALID, DATAVALID_ALL, TMOERR, OVERRUN, BUSY and RDLAT to 0.
REQ-031 PRMBDET SHALL be 0 while RSTN=0; reset mid-burst SHALL abort the burst without a further DATAVALID cycle.
REQ-032 Release SHALL be synchronous to SCLK: the first READ is accepted at the first edge after RSTN rises.

Configuration
REQ-033 Macro DQS_READ_GATE_LATMON_EN defined: the RDLAT capture registers and the OVERRUN flag SHALL be implemented per REQ-015, REQ-020, REQ-022 and REQ-028.
REQ-034 Macro DQS_READ_GATE_LATMON_EN undefined: RDLAT and OVERRUN SHALL be tied to 0 with no storage; gating, detect, valid and timeout behaviour SHALL be unchanged.

Verification
REQ-035 LANES=2, defaults. READ at cycle 0; DQSS lane0 low at cycles 1-2 and high at 3 -> PRMBDET[0] at 3, DATAVALID[0] at cycles 4-7, RDLAT[3:0]=2.
REQ-036 Lane1 has DQSS low at 1-4 and high at 5, with lane0 as in REQ-035 -> DATAVALID[1] at 6-9, DATAVALID_ALL at 6-7 only, BUSY low from cycle 10.
REQ-037 DQSS held high on lane1 after READ -> TMOERR[1]=1 and lane1 IDLE after TIMEOUT=15 wait cycles; the next accepted READ clears TMOERR[1].
REQ-038 READ again at cycle 4 while busy -> ignored and OVERRUN=1 (macro defined) or OVERRUN=0 (macro undefined).
REQ-039 RSTN pulled low at cycle 5 during BURST -> DATAVALID and DQSGATE immediately 0; READ at the first edge after release is accepted normally.
REQ-040 PRMB_CYC=2 with a single low sample before the DQSS rise -> no detect; a later 2-low-then-high sequence detects.

Source files
------------

// File: rtl/dqs_read_gate.sv
// Per-lane DQS read gating: opens the gate on READ, finds the preamble, then flags BURST_LEN/2 valid cycles.
// Optional latency monitor (RDLAT capture, OVERRUN flag) is built when DQS_READ_GATE_LATMON_EN is defined.
module dqs_read_gate #(
  parameter int unsigned LANES     = 2,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned PRMB_CYC  = 1,
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned LATW      = 4
) (
  input  logic                    SCLK,
  input  logic                    RSTN,
  input  logic                    READ,
  input  logic [LANES-1:0]        DQSS,
  output logic [LANES-1:0]        DQSGATE,
  output logic [LANES-1:0]        PRMBDET,
  output logic [LANES-1:0]        DATAVALID,
  output logic                    DATAVALID_ALL,
  output logic [LANES-1:0]        TMOERR,
  output logic                    OVERRUN,
  output logic                    BUSY,
  output logic [LANES*LATW-1:0]   RDLAT
);

  localparam int unsigned BEATS   = BURST_LEN / 2;
  localparam int unsigned BCW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LRW     = 2;
  localparam int unsigned LAT_MAX = (1 << LATW) - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } state_e;

  state_e          state_q [LANES];
  state_e          state_d [LANES];
  logic [LATW-1:0] wcnt_q  [LANES];
  logic [LATW-1:0] wcnt_d  [LANES];
  logic [LRW-1:0]  lrun_q  [LANES];
  logic [LRW-1:0]  lrun_d  [LANES];
  logic [BCW-1:0]  bcnt_q  [LANES];
  logic [BCW-1:0]  bcnt_d  [LANES];

  logic [LANES-1:0] gate_q, gate_d;
  logic [LANES-1:0] dv_q, dv_d;
  logic [LANES-1:0] tmo_q, tmo_d;
  logic [LANES-1:0] det_c;
  logic             dvall_q, dvall_d;
  logic             busy_q, busy_d;
  logic             accept_c;

  // A READ only starts a burst when every lane has returned to IDLE.
  assign accept_c = READ & ~busy_q;

  // Per-lane next state; registered outputs follow the next state.
  always_comb begin
    gate_d  = '0;
    dv_d    = '0;
    tmo_d   = tmo_q;
    det_c   = '0;
    busy_d  = 1'b0;
    dvall_d = 1'b0;
    for (int i = 0; i < int'(LANES); i++) begin
      state_d[i] = state_q[i];
      wcnt_d[i]  = wcnt_q[i];
      lrun_d[i]  = lrun_q[i];
      bcnt_d[i]  = bcnt_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (accept_c) begin
            state_d[i] = S_WAIT;
            wcnt_d[i]  = '0;
            lrun_d[i]  = '0;
            tmo_d[i]   = 1'b0;
          end
        end
        S_WAIT: begin
          det_c[i] = DQSS[i] && (lrun_q[i] >= LRW'(PRMB_CYC));
          if (det_c[i]) begin
            state_d[i] = S_BURST;
            bcnt_d[i]  = '0;
          end else begin
            if (DQSS[i]) begin
              lrun_d[i] = '0;
            end else if (lrun_q[i] < LRW'(PRMB_CYC)) begin
              lrun_d[i] = lrun_q[i] + LRW'(1);
            end
            // Detect takes priority over an expiring wait window.
            if (wcnt_q[i] == LATW'(TIMEOUT - 1)) begin
              state_d[i] = S_IDLE;
              tmo_d[i]   = 1'b1;
            end else begin
              wcnt_d[i] = wcnt_q[i] + LATW'(1);
            end
          end
        end
        S_BURST: begin
          if (bcnt_q[i] == BCW'(BEATS - 1)) begin
            state_d[i] = S_IDLE;
          end else begin
            bcnt_d[i] = bcnt_q[i] + BCW'(1);
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
      gate_d[i] = (state_d[i] != S_IDLE);
      dv_d[i]   = (state_d[i] == S_BURST);
    end
    busy_d  = |gate_d;
    dvall_d = &dv_d;
  end

  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < int'(LANES); i++) begin
        state_q[i] <= S_IDLE;
        wcnt_q[i]  <= '0;
        lrun_q[i]  <= '0;
        bcnt_q[i]  <= '0;
      end
      gate_q  <= '0;
      dv_q    <= '0;
      tmo_q   <= '0;
      dvall_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      for (int i = 0; i < int'(LANES); i++) begin
        state_q[i] <= state_d[i];
        wcnt_q[i]  <= wcnt_d[i];
        lrun_q[i]  <= lrun_d[i];
        bcnt_q[i]  <= bcnt_d[i];
      end
      gate_q  <= gate_d;
      dv_q    <= dv_d;
      tmo_q   <= tmo_d;
      dvall_q <= dvall_d;
      busy_q  <= busy_d;
    end
  end

  assign DQSGATE       = gate_q;
  assign PRMBDET       = det_c;
  assign DATAVALID     = dv_q;
  assign DATAVALID_ALL = dvall_q;
  assign TMOERR        = tmo_q;
  assign BUSY          = busy_q;

`ifdef DQS_READ_GATE_LATMON_EN
  logic [LATW-1:0] lat_q [LANES];
  logic [LATW-1:0] lat_d [LANES];
  logic            ovr_q, ovr_d;

  // Latency capture on detect, sticky overrun on a READ while busy.
  always_comb begin
    ovr_d = ovr_q;
    if (accept_c) begin
      ovr_d = 1'b0;
    end else if (READ) begin
      ovr_d = 1'b1;
    end
    for (int i = 0; i < int'(LANES); i++) begin
      lat_d[i] = lat_q[i];
      if (det_c[i]) begin
        lat_d[i] = (32'(wcnt_q[i]) >= LAT_MAX) ? LATW'(LAT_MAX) : wcnt_q[i];
      end
    end
  end

  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) begin
      ovr_q <= 1'b0;
      for (int i = 0; i < int'(LANES); i++) begin
        lat_q[i] <= '0;
      end
    end else begin
      ovr_q <= ovr_d;
      for (int i = 0; i < int'(LANES); i++) begin
        lat_q[i] <= lat_d[i];
      end
    end
  end

  for (genvar g = 0; g < int'(LANES); g++) begin : g_lat
    assign RDLAT[g*LATW +: LATW] = lat_q[g];
  end
  assign OVERRUN = ovr_q;
`else
  assign RDLAT   = '0;
  assign OVERRUN = 1'b0;
`endif

endmodule

// File: tb/tb_dqs_read_gate.sv
// Randomized bench for dqs_read_gate: two instances (PRMB_CYC=1 and 2) share stimulus and are
// compared every cycle against a cycle-number based reference model.
module tb_dqs_read_gate;

  localparam int LANES     = 2;
  localparam int BURST_LEN = 8;
  localparam int TIMEOUT   = 15;
  localparam int LATW      = 4;
  localparam int BEATS     = BURST_LEN / 2;
  localparam int LAT_MAX   = (1 << LATW) - 1;
  localparam int NI        = 2;
`ifdef DQS_READ_GATE_LATMON_EN
  localparam bit LATMON = 1'b1;
`else
  localparam bit LATMON = 1'b0;
`endif

  logic                               SCLK;
  logic                               RSTN;
  logic                               READ;
  logic [LANES-1:0]                   DQSS;
  logic [NI-1:0][LANES-1:0]           gate_w, det_w, dv_w, tmo_w;
  logic [NI-1:0]                      dvall_w, ovr_w, busy_w;
  logic [NI-1:0][LANES*LATW-1:0]      lat_w;

  dqs_read_gate #(.LANES(LANES), .BURST_LEN(BURST_LEN), .PRMB_CYC(1), .TIMEOUT(TIMEOUT), .LATW(LATW))
  u_dut_p1 (
    .SCLK(SCLK), .RSTN(RSTN), .READ(READ), .DQSS(DQSS),
    .DQSGATE(gate_w[0]), .PRMBDET(det_w[0]), .DATAVALID(dv_w[0]), .DATAVALID_ALL(dvall_w[0]),
    .TMOERR(tmo_w[0]), .OVERRUN(ovr_w[0]), .BUSY(busy_w[0]), .RDLAT(lat_w[0])
  );

  dqs_read_gate #(.LANES(LANES), .BURST_LEN(BURST_LEN), .PRMB_CYC(2), .TIMEOUT(TIMEOUT), .LATW(LATW))
  u_dut_p2 (
    .SCLK(SCLK), .RSTN(RSTN), .READ(READ), .DQSS(DQSS),
    .DQSGATE(gate_w[1]), .PRMBDET(det_w[1]), .DATAVALID(dv_w[1]), .DATAVALID_ALL(dvall_w[1]),
    .TMOERR(tmo_w[1]), .OVERRUN(ovr_w[1]), .BUSY(busy_w[1]), .RDLAT(lat_w[1])
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Reference model: lane mode 0=idle 1=wait 2=burst, with absolute cycle bookkeeping.
  int md   [NI][LANES];
  int ent  [NI][LANES];
  int lhi  [NI][LANES];
  int bend [NI][LANES];
  int lat  [NI][LANES];
  bit tmo  [NI][LANES];
  bit ovr  [NI];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int prmb(int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic bit m_busy(int k);
    bit b = 1'b0;
    for (int i = 0; i < LANES; i++) if (md[k][i] != 0) b = 1'b1;
    return b;
  endfunction

  // Detect: high sample in WAIT preceded by at least PRMB_CYC low samples taken in WAIT.
  function automatic bit m_det(int k, int i, logic [LANES-1:0] d);
    return (md[k][i] == 1) && d[i] && ((cyc - lhi[k][i] - 1) >= prmb(k));
  endfunction

  task automatic m_reset();
    for (int k = 0; k < NI; k++) begin
      ovr[k] = 1'b0;
      for (int i = 0; i < LANES; i++) begin
        md[k][i] = 0; ent[k][i] = 0; lhi[k][i] = 0; bend[k][i] = 0; lat[k][i] = 0; tmo[k][i] = 1'b0;
      end
    end
  endtask

  task automatic m_step(int k, bit rd, logic [LANES-1:0] d);
    if (rd && !m_busy(k)) begin
      ovr[k] = 1'b0;
      for (int i = 0; i < LANES; i++) begin
        md[k][i] = 1; ent[k][i] = cyc + 1; lhi[k][i] = cyc; tmo[k][i] = 1'b0;
      end
    end else begin
      if (rd) ovr[k] = 1'b1;
      for (int i = 0; i < LANES; i++) begin
        if (md[k][i] == 1) begin
          if (m_det(k, i, d)) begin
            md[k][i]   = 2;
            bend[k][i] = cyc + BEATS;
            lat[k][i]  = (cyc - ent[k][i] > LAT_MAX) ? LAT_MAX : cyc - ent[k][i];
          end else if (cyc - ent[k][i] == TIMEOUT - 1) begin
            md[k][i]  = 0;
            tmo[k][i] = 1'b1;
          end else if (d[i]) begin
            lhi[k][i] = cyc;
          end
        end else if (md[k][i] == 2) begin
          if (cyc + 1 > bend[k][i]) md[k][i] = 0;
        end
      end
    end
  endtask

  task automatic check_outs(int k);
    logic [LANES-1:0]      eg, ed, et;
    logic [LANES*LATW-1:0] el;
    string p;
    p  = $sformatf("p%0d", k + 1);
    el = '0;
    for (int i = 0; i < LANES; i++) begin
      eg[i] = (md[k][i] != 0);
      ed[i] = (md[k][i] == 2);
      et[i] = tmo[k][i];
      if (LATMON) el[i*LATW +: LATW] = LATW'(lat[k][i]);
    end
    check({p, ".dqsgate"},   64'(gate_w[k]),  64'(eg));
    check({p, ".datavalid"}, 64'(dv_w[k]),    64'(ed));
    check({p, ".dv_all"},    64'(dvall_w[k]), 64'(&ed));
    check({p, ".busy"},      64'(busy_w[k]),  64'(|eg));
    check({p, ".tmoerr"},    64'(tmo_w[k]),   64'(et));
    check({p, ".overrun"},   64'(ovr_w[k]),   64'(LATMON & ovr[k]));
    check({p, ".rdlat"},     64'(lat_w[k]),   64'(el));
  endtask

  // One SCLK cycle: drive, check the combinational detect, advance model and DUT, check registers.
  task automatic run_cycle(input bit rd, input logic [LANES-1:0] d);
    logic [LANES-1:0] ep;
    READ = rd;
    DQSS = d;
    #1;
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < LANES; i++) ep[i] = m_det(k, i, d);
      check($sformatf("p%0d.prmbdet", k + 1), 64'(det_w[k]), 64'(ep));
    end
    for (int k = 0; k < NI; k++) m_step(k, rd, d);
    @(posedge SCLK);
    cyc++;
    #1;
    for (int k = 0; k < NI; k++) check_outs(k);
  endtask

  // Mid-cycle asynchronous reset, held across one edge, released between edges.
  task automatic pulse_reset();
    #2;
    RSTN = 1'b0;
    m_reset();
    #1;
    for (int k = 0; k < NI; k++) begin
      check_outs(k);
      check($sformatf("p%0d.prmbdet_rst", k + 1), 64'(det_w[k]), 64'd0);
    end
    @(posedge SCLK);
    cyc++;
    #1;
    for (int k = 0; k < NI; k++) check_outs(k);
    @(negedge SCLK);
    RSTN = 1'b1;
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && (m_busy(0) || m_busy(1)); n++) run_cycle(1'b0, '1);
    check("drain_idle", 64'(busy_w), 64'd0);
  endtask

  int pct [LANES];

  initial begin
    RSTN = 1'b0;
    READ = 1'b0;
    DQSS = '0;
    m_reset();
    repeat (2) begin
      @(posedge SCLK);
      cyc++;
    end
    #1;
    for (int k = 0; k < NI; k++) check_outs(k);
    @(negedge SCLK);
    RSTN = 1'b1;

    // Lane0 detects at 3, lane1 at 5, with a READ while busy at 4.
    cyc = 0;
    run_cycle(1'b1, 2'b00);
    run_cycle(1'b0, 2'b00);
    run_cycle(1'b0, 2'b00);
    run_cycle(1'b0, 2'b01);
    check("dir.dv0_c4", 64'(dv_w[0][0]), 64'd1);
    check("dir.rdlat0", 64'(lat_w[0][3:0]), LATMON ? 64'd2 : 64'd0);
    run_cycle(1'b1, 2'b00);
    run_cycle(1'b0, 2'b11);
    check("dir.overrun", 64'(ovr_w[0]), 64'(LATMON));
    check("dir.rdlat1", 64'(lat_w[0][7:4]), LATMON ? 64'd4 : 64'd0);
    check("dir.dvall_c6", 64'(dvall_w[0]), 64'd1);
    run_cycle(1'b0, 2'b11);
    run_cycle(1'b0, 2'b11);
    check("dir.dvall_c8", 64'(dvall_w[0]), 64'd0);
    check("dir.dv1_c8", 64'(dv_w[0][1]), 64'd1);
    run_cycle(1'b0, 2'b11);
    run_cycle(1'b0, 2'b11);
    check("dir.busy_c10", 64'(busy_w[0]), 64'd0);

    // Reset during BURST, then READ on the first edge after release.
    run_cycle(1'b1, 2'b00);
    run_cycle(1'b0, 2'b00);
    run_cycle(1'b0, 2'b00);
    run_cycle(1'b0, 2'b11);
    run_cycle(1'b0, 2'b00);
    pulse_reset();
    check("dir.rst_dv", 64'(dv_w[0]), 64'd0);
    check("dir.rst_gate", 64'(gate_w[0]), 64'd0);
    run_cycle(1'b1, 2'b00);
    check("dir.read_after_rst", 64'(busy_w[0]), 64'd1);

    // Lane1 held high: times out after TIMEOUT wait cycles; next READ clears the flag.
    run_cycle(1'b0, 2'b10);
    run_cycle(1'b0, 2'b10);
    repeat (TIMEOUT - 2) run_cycle(1'b0, 2'b11);
    check("dir.tmo1", 64'(tmo_w[0][1]), 64'd1);
    check("dir.tmo1_gate", 64'(gate_w[0][1]), 64'd0);
    drain();
    run_cycle(1'b1, 2'b00);
    check("dir.tmo1_clr", 64'(tmo_w[0][1]), 64'd0);
    drain();

    // A single low sample is not a preamble when two are required.
    run_cycle(1'b1, 2'b00);
    run_cycle(1'b0, 2'b11);
    run_cycle(1'b0, 2'b00);
    run_cycle(1'b0, 2'b11);
    check("dir.p1_det", 64'(dv_w[0]), 64'd3);
    check("dir.p2_nodet", 64'(dv_w[1]), 64'd0);
    run_cycle(1'b0, 2'b00);
    run_cycle(1'b0, 2'b00);
    run_cycle(1'b0, 2'b11);
    check("dir.p2_det", 64'(dv_w[1]), 64'd3);
    drain();

    // Random traffic with per-lane DQS high density re-chosen every 40 cycles.
    for (int n = 0; n < 3000; n++) begin
      logic [LANES-1:0] d;
      if (n % 40 == 0) begin
        for (int i = 0; i < LANES; i++) begin
          case ($urandom_range(0, 3))
            0:       pct[i] = 0;
            1:       pct[i] = 15;
            2:       pct[i] = 50;
            default: pct[i] = 100;
          endcase
        end
      end
      for (int i = 0; i < LANES; i++) d[i] = ($urandom_range(0, 99) < pct[i]);
      if ($urandom_range(0, 399) == 0) pulse_reset();
      run_cycle($urandom_range(0, 7) == 0, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
